dpram_fifo_ctrl: RTL and testbench

Synchronous FIFO controller placed directly upstream of the 16x8 dual-port RAM (dual_port). It turns push/pop requests into RAM port-A write and port-B read controls, and maintains the pointers, occupancy and status flags. The RAM provides the storage, so the block is pure control plus a read-valid pipeline. Port A of the RAM is write-only and port B is read-only under this controller. Integration ties the RAM's re_a and we_b inputs low and drives its rst from this block's reset domain.

---
 rtl/dpram_pkg.sv | 24 ++
 rtl/dpram_fifo_ctrl_if.sv | 38 +++
 rtl/dpram_fifo_ctrl.sv | 92 +++++++++
 tb/tb_dpram_fifo_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared constants, operation encoding and pointer helper for the dual-port-RAM FIFO controller.
package dpram_pkg;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefAddrW = 4;
    localparam int unsigned DefDepth = 2 ** DefAddrW;
    localparam int unsigned PtrW     = DefAddrW + 1;

    // {push_ok, pop_ok} packed into one code so the occupancy update is a single decode.
    typedef enum logic [1:0] {
        OpIdle = 2'b00,
        OpPop  = 2'b01,
        OpPush = 2'b10,
        OpBoth = 2'b11
    } op_e;

    // Next pointer value; the extra MSB above addr_w is the wrap bit.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned addr_w);
        int unsigned mask;
        mask = (32'd1 << (addr_w + 1)) - 32'd1;
        return (ptr + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// Push/pop, status and RAM-port signals of the FIFO controller; master drives the controller.
interface dpram_fifo_ctrl_if #(
    parameter int unsigned DATA_W = dpram_pkg::DefDataW,
    parameter int unsigned ADDR_W = dpram_pkg::DefAddrW
);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;
    logic              ram_we_a;
    logic [ADDR_W-1:0] ram_add_a;
    logic [DATA_W-1:0] ram_data_a;
    logic              ram_re_b;
    logic [ADDR_W-1:0] ram_add_b;
    logic [DATA_W-1:0] ram_out_b;

    modport master (
        output wr_en, wr_data, rd_en, ram_out_b,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
        input  overflow, underflow, ram_we_a, ram_add_a, ram_data_a, ram_re_b, ram_add_b
    );

    modport slave (
        input  wr_en, wr_data, rd_en, ram_out_b,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
        output overflow, underflow, ram_we_a, ram_add_a, ram_data_a, ram_re_b, ram_add_b
    );

endinterface

// File: rtl/dpram_fifo_ctrl.sv
// Synchronous FIFO controller driving write-only port A and read-only port B of a dual-port RAM.
module dpram_fifo_ctrl
    import dpram_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned AF_LEVEL = 14,
    parameter int unsigned AE_LEVEL = 2
) (
    input logic              clk,
    input logic              rst,
    dpram_fifo_ctrl_if.slave fifo_if
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam int unsigned CntW  = ADDR_W + 1;

    logic [CntW-1:0] wptr_q, wptr_d;
    logic [CntW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            rd_valid_q, overflow_q, underflow_q;
    logic            full, empty;
    logic            push_ok, pop_ok;
    op_e             op;

    // Status flags decode the registered occupancy only.
    always_comb begin
        full  = (count_q == CntW'(Depth));
        empty = (count_q == '0);
    end

    // Acceptance looks only at registered flags: no push-through-full, no pop fall-through.
    always_comb begin
        push_ok = fifo_if.wr_en & ~full;
        pop_ok  = fifo_if.rd_en & ~empty;
        op      = op_e'({push_ok, pop_ok});
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = CntW'(ptr_next(32'(wptr_q), ADDR_W));
        end
        if (pop_ok) begin
            rptr_d = CntW'(ptr_next(32'(rptr_q), ADDR_W));
        end
        unique case (op)
            OpPush:  count_d = count_q + CntW'(1);
            OpPop:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rd_valid_q  <= pop_ok;
            overflow_q  <= fifo_if.wr_en & full;
            underflow_q <= fifo_if.rd_en & empty;
        end
    end

    always_comb begin
        fifo_if.ram_we_a     = push_ok;
        fifo_if.ram_add_a    = wptr_q[ADDR_W-1:0];
        fifo_if.ram_data_a   = fifo_if.wr_data;
        fifo_if.ram_re_b     = pop_ok;
        fifo_if.ram_add_b    = rptr_q[ADDR_W-1:0];
        // RAM output is already registered; pass it through and let rd_valid qualify it.
        fifo_if.rd_data      = fifo_if.ram_out_b;
        fifo_if.rd_valid     = rd_valid_q;
        fifo_if.full         = full;
        fifo_if.empty        = empty;
        fifo_if.almost_full  = (count_q >= CntW'(AF_LEVEL));
        fifo_if.almost_empty = (count_q <= CntW'(AE_LEVEL));
        fifo_if.count        = count_q;
        fifo_if.overflow     = overflow_q;
        fifo_if.underflow    = underflow_q;
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl with a behavioural 16x8 RAM and a data scoreboard.
module tb_dpram_fifo_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dpram_fifo_ctrl_if bus ();

    dpram_fifo_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .fifo_if (bus)
    );

    // RAM model: synchronous write on A, registered read on B.
    logic [7:0] mem [16];
    logic [7:0] ram_q;
    always @(posedge clk) begin
        if (bus.ram_we_a) mem[bus.ram_add_a] <= bus.ram_data_a;
        if (bus.ram_re_b) ram_q <= mem[bus.ram_add_b];
    end
    assign bus.ram_out_b = ram_q;

    int         checks   = 0;
    int         failures = 0;
    int         mcount   = 0;
    logic [4:0] mwptr    = '0;
    logic [4:0] mrptr    = '0;
    logic [7:0] exp_q[$];
    bit         mon_en   = 1'b0;
    bit         exp_valid, exp_ovf, exp_unf, exp_we, exp_re;
    logic [3:0] exp_add_a, exp_add_b;
    logic [7:0] exp_data_a;

    // One clock of stimulus; the model tracks what the controller should do.
    task automatic drive(input bit we, input logic [7:0] wd, input bit re);
        bit push_ok, pop_ok;
        int old;
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        old         = mcount;
        push_ok     = we && (old != 16);
        pop_ok      = re && (old != 0);
        exp_we      = push_ok;
        exp_re      = pop_ok;
        exp_add_a   = mwptr[3:0];
        exp_add_b   = mrptr[3:0];
        exp_data_a  = wd;
        @(posedge clk);
        #1;
        if (push_ok) begin
            exp_q.push_back(wd);
            mwptr = mwptr + 5'd1;
        end
        if (pop_ok) mrptr = mrptr + 5'd1;
        mcount    = old + int'(push_ok) - int'(pop_ok);
        exp_valid = pop_ok;
        exp_ovf   = we && (old == 16);
        exp_unf   = re && (old == 0);
    endtask

    always @(negedge clk) begin
        logic [7:0] w;
        if (mon_en) begin
            checks++;
            if (bus.count !== 5'(mcount)) begin
                failures++;
                $display("FAIL count actual=%0d required=%0d t=%0t", bus.count, mcount, $time);
            end
            checks++;
            if ({bus.full, bus.empty, bus.almost_full, bus.almost_empty} !==
                {mcount == 16, mcount == 0, mcount >= 14, mcount <= 2}) begin
                failures++;
                $display("FAIL flags actual=%b%b%b%b count=%0d t=%0t", bus.full, bus.empty,
                         bus.almost_full, bus.almost_empty, mcount, $time);
            end
            checks++;
            if ({bus.rd_valid, bus.overflow, bus.underflow} !== {exp_valid, exp_ovf, exp_unf}) begin
                failures++;
                $display("FAIL valid_ovf_unf actual=%b%b%b required=%b%b%b t=%0t", bus.rd_valid,
                         bus.overflow, bus.underflow, exp_valid, exp_ovf, exp_unf, $time);
            end
            checks++;
            if ({bus.ram_we_a, bus.ram_re_b} !== {exp_we, exp_re}) begin
                failures++;
                $display("FAIL ram_en actual=%b%b required=%b%b t=%0t", bus.ram_we_a,
                         bus.ram_re_b, exp_we, exp_re, $time);
            end
            if (exp_we) begin
                checks++;
                if ({bus.ram_add_a, bus.ram_data_a} !== {exp_add_a, exp_data_a}) begin
                    failures++;
                    $display("FAIL ram_a actual=%h/%h required=%h/%h t=%0t", bus.ram_add_a,
                             bus.ram_data_a, exp_add_a, exp_data_a, $time);
                end
            end
            if (exp_re) begin
                checks++;
                if (bus.ram_add_b !== exp_add_b) begin
                    failures++;
                    $display("FAIL ram_add_b actual=%h required=%h t=%0t", bus.ram_add_b,
                             exp_add_b, $time);
                end
            end
            if (exp_valid && bus.rd_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard actual=extra_word required=none t=%0t", $time);
                end else begin
                    w = exp_q.pop_front();
                    if (bus.rd_data !== w) begin
                        failures++;
                        $display("FAIL rd_data actual=%h required=%h t=%0t", bus.rd_data, w,
                                 $time);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.empty, bus.almost_empty, bus.full, bus.almost_full} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_flags actual=%b%b%b%b required=1100", bus.empty,
                     bus.almost_empty, bus.full, bus.almost_full);
        end
        checks++;
        if (bus.count !== 5'd0) begin
            failures++;
            $display("FAIL reset_count actual=%0d required=0", bus.count);
        end
        checks++;
        if ({bus.rd_valid, bus.ram_we_a, bus.ram_re_b, bus.overflow, bus.underflow} !== 5'b0)
        begin
            failures++;
            $display("FAIL reset_ctrl actual=%b%b%b%b%b required=00000", bus.rd_valid,
                     bus.ram_we_a, bus.ram_re_b, bus.overflow, bus.underflow);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (2) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 8'(8'h11 + i), 1'b0);
            if (i == 2 || i == 12 || i == 13) begin
                checks++;
                if ({bus.almost_empty, bus.almost_full} !== {1'b0, i == 13}) begin
                    failures++;
                    $display("FAIL fill_ae_af n=%0d actual=%b%b required=0%b", i + 1,
                             bus.almost_empty, bus.almost_full, i == 13);
                end
            end
        end
        for (int i = 0; i < 15; i++) drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (bus.empty !== 1'b1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_empty actual=%b left=%0d required=1 left=0", bus.empty,
                     exp_q.size());
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h20 + i), 1'b0);
        drive(1'b1, 8'hAA, 1'b0);
        checks++;
        if ({bus.full, bus.overflow, bus.count} !== {1'b1, 1'b1, 5'd16}) begin
            failures++;
            $display("FAIL overflow actual=%b%b/%0d required=11/16", bus.full, bus.overflow,
                     bus.count);
        end
        drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_pulse actual=%b required=0", bus.overflow);
        end
        for (int i = 0; i < 16; i++) drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_underflow();
        drive(1'b1, 8'h5C, 1'b1);
        checks++;
        if ({bus.underflow, bus.rd_valid, bus.count} !== {1'b1, 1'b0, 5'd1}) begin
            failures++;
            $display("FAIL underflow actual=%b%b/%0d required=10/1", bus.underflow,
                     bus.rd_valid, bus.count);
        end
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL underflow_drain actual=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back_wrap();
        for (int i = 0; i < 10; i++) drive(1'b1, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 8'(8'h80 + i), 1'b1);
            checks++;
            if (bus.count !== 5'd10) begin
                failures++;
                $display("FAIL wrap_count i=%0d actual=%0d required=10", i, bus.count);
            end
        end
        for (int i = 0; i < 10; i++) drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_drain actual=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h60 + i), 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        checks++;
        if ({bus.count, bus.rd_valid} !== {5'd7, 1'b1}) begin
            failures++;
            $display("FAIL pre_reset actual=%0d/%b required=7/1", bus.count, bus.rd_valid);
        end
        bus.rd_en = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.count, bus.rd_valid, bus.empty} !== {5'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL async_reset actual=%0d/%b/%b required=0/0/1", bus.count,
                     bus.rd_valid, bus.empty);
        end
        exp_q.delete();
        mcount = 0; mwptr = '0; mrptr = '0;
        exp_valid = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
        repeat (2) drive(1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        drive(1'b1, 8'h3E, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL post_reset_pop actual=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        exp_valid = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
        exp_we = 1'b0; exp_re = 1'b0;
        exp_add_a = '0; exp_add_b = '0; exp_data_a = '0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_back_to_back_wrap();
        test_reset_mid();
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
